// File: rtl/ifu_lsu_arb_if.sv
// rtl/ifu_lsu_arb_if.sv - IFU, LSU and shared memory port bundle for ifu_lsu_arb
interface ifu_lsu_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_rsp_valid;
  logic [DATA_W-1:0] ifu_rdata;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_wen;
  logic [DATA_W-1:0] lsu_wdata;
  logic [MASK_W-1:0] lsu_wmask;
  logic              lsu_rsp_valid;
  logic [DATA_W-1:0] lsu_rdata;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_rsp_valid, ifu_rdata,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_rsp_valid, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rdata,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/ifu_lsu_arb.sv
// rtl/ifu_lsu_arb.sv - single-outstanding IFU/LSU arbiter onto one shared memory port
module ifu_lsu_arb #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STREAK_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  ifu_lsu_arb_if.slave  bus
);
  localparam int MASK_W = DATA_W / 8;
  localparam int SW     = $clog2(STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_SAT = SW'(STREAK_MAX);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SW-1:0]     r_streak;
  logic              r_owner_lsu;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic [DATA_W-1:0] r_wdata;
  logic [MASK_W-1:0] r_wmask;
  logic              w_grant_ifu;
  logic              w_grant_lsu;
  logic              w_rsp;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_ifu = 1'b0;
    w_grant_lsu = 1'b0;
    w_rsp       = 1'b0;
    case (r_state)
      S_IDLE: begin
        // LSU wins ties until it has starved a waiting IFU STREAK_MAX times
        w_grant_lsu = bus.lsu_req_valid && (!bus.ifu_req_valid || (r_streak != STREAK_SAT));
        w_grant_ifu = bus.ifu_req_valid && !w_grant_lsu;
        if (w_grant_lsu || w_grant_ifu) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (bus.mem_req_ready) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (bus.mem_rsp_valid) begin
          // a reset landing on the response cycle suppresses the pulse
          w_rsp       = rst;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_streak    <= '0;
      r_owner_lsu <= 1'b0;
      r_addr      <= '0;
      r_wen       <= 1'b0;
      r_wdata     <= '0;
      r_wmask     <= '0;
    end else if (w_grant_lsu) begin
      r_owner_lsu <= 1'b1;
      r_addr      <= bus.lsu_addr;
      r_wen       <= bus.lsu_wen;
      r_wdata     <= bus.lsu_wdata;
      r_wmask     <= bus.lsu_wmask;
      if (bus.ifu_req_valid && (r_streak != STREAK_SAT)) r_streak <= r_streak + 1'b1;
    end else if (w_grant_ifu) begin
      r_owner_lsu <= 1'b0;
      r_addr      <= bus.ifu_addr;
      r_wen       <= 1'b0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_streak    <= '0;
    end
  end

  assign bus.ifu_req_ready = w_grant_ifu;
  assign bus.lsu_req_ready = w_grant_lsu;

  assign bus.mem_req_valid = (r_state == S_REQ);
  assign bus.mem_addr      = r_addr;
  assign bus.mem_wen       = r_wen;
  assign bus.mem_wdata     = r_wdata;
  assign bus.mem_wmask     = r_wmask;

  assign bus.ifu_rsp_valid = w_rsp && !r_owner_lsu;
  assign bus.lsu_rsp_valid = w_rsp && r_owner_lsu;
  assign bus.ifu_rdata     = bus.ifu_rsp_valid ? bus.mem_rdata : '0;
  assign bus.lsu_rdata     = bus.lsu_rsp_valid ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_ifu_lsu_arb.sv
// tb/tb_ifu_lsu_arb.sv - scoreboard bench for ifu_lsu_arb
module tb_ifu_lsu_arb;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STREAK_MAX = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mreq_t;

  typedef struct packed {
    logic        lsu;
    logic [31:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ifu_lsu_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ifu_lsu_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STREAK_MAX(STREAK_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  mreq_t exp_req[$];
  rsp_t  exp_rsp[$];
  bit    grants[$];
  int    ifu_left = 0;
  int    lsu_left = 0;
  bit    ifu_fix = 1'b0;
  bit    lsu_fix = 1'b0;
  logic [31:0] ifu_fix_addr = '0;
  mreq_t lsu_fix_req = '0;
  int    hold_cnt = 0;
  bit    rand_ready = 1'b0;
  bit    spurious = 1'b0;
  bit    pending = 1'b0;
  logic [31:0] pend_addr = '0;
  int    g_cyc = 0;
  int    hs_cyc = 0;
  int    rsp_cyc = 0;
  int    n_hs = 0;
  int    n_rsp = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // requester and memory stimulus, applied just after each rising edge
  initial begin
    bus.ifu_req_valid = 1'b0;
    bus.ifu_addr      = '0;
    bus.lsu_req_valid = 1'b0;
    bus.lsu_addr      = '0;
    bus.lsu_wen       = 1'b0;
    bus.lsu_wdata     = '0;
    bus.lsu_wmask     = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.ifu_req_valid = (ifu_left > 0);
      bus.ifu_addr      = ifu_fix ? ifu_fix_addr : $urandom;
      bus.lsu_req_valid = (lsu_left > 0);
      bus.lsu_addr      = lsu_fix ? lsu_fix_req.addr  : $urandom;
      bus.lsu_wen       = lsu_fix ? lsu_fix_req.wen   : 1'($urandom_range(0, 1));
      bus.lsu_wdata     = lsu_fix ? lsu_fix_req.wdata : $urandom;
      bus.lsu_wmask     = lsu_fix ? lsu_fix_req.wmask : 4'($urandom);
      if (bus.mem_req_valid) begin
        if (hold_cnt > 0) begin
          bus.mem_req_ready = 1'b0;
          hold_cnt--;
        end else begin
          bus.mem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
      end else begin
        bus.mem_req_ready = 1'($urandom_range(0, 1));
      end
      if (pending) begin
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = mem_data(pend_addr);
        pending           = 1'b0;
      end else begin
        bus.mem_rsp_valid = spurious;
        bus.mem_rdata     = $urandom;
      end
    end
  end

  // scoreboard: push on grant, compare on memory request and on response
  always @(negedge clk) begin
    mreq_t m;
    rsp_t  e;
    cyc++;
    if (bus.ifu_req_valid && bus.ifu_req_ready) begin
      grants.push_back(1'b0);
      g_cyc = cyc;
      ifu_left--;
      m.addr = bus.ifu_addr; m.wen = 1'b0; m.wdata = '0; m.wmask = '0;
      exp_req.push_back(m);
      e.lsu = 1'b0; e.data = mem_data(bus.ifu_addr);
      exp_rsp.push_back(e);
    end
    if (bus.lsu_req_valid && bus.lsu_req_ready) begin
      grants.push_back(1'b1);
      g_cyc = cyc;
      lsu_left--;
      m.addr = bus.lsu_addr; m.wen = bus.lsu_wen; m.wdata = bus.lsu_wdata; m.wmask = bus.lsu_wmask;
      exp_req.push_back(m);
      e.lsu = 1'b1; e.data = mem_data(bus.lsu_addr);
      exp_rsp.push_back(e);
    end
    check("ready_excl", 96'(bus.ifu_req_ready && bus.lsu_req_ready), 96'(0));
    if (bus.mem_req_valid) begin
      if (exp_req.size() == 0) begin
        check("mem_req_unexp", 96'(1), 96'(0));
      end else begin
        m.addr = bus.mem_addr; m.wen = bus.mem_wen; m.wdata = bus.mem_wdata; m.wmask = bus.mem_wmask;
        check("mem_req_fields", 96'(m), 96'(exp_req[0]));
      end
      if (bus.mem_req_ready) begin
        pending   = 1'b1;
        pend_addr = bus.mem_addr;
        hs_cyc    = cyc;
        n_hs++;
        if (exp_req.size() != 0) void'(exp_req.pop_front());
      end
    end
    if (bus.ifu_rsp_valid || bus.lsu_rsp_valid) begin
      n_rsp++;
      rsp_cyc = cyc;
      check("rsp_both", 96'(bus.ifu_rsp_valid && bus.lsu_rsp_valid), 96'(0));
      if (exp_rsp.size() == 0) begin
        check("rsp_unexp", 96'(1), 96'(0));
      end else begin
        e = exp_rsp.pop_front();
        check("rsp_owner", 96'(bus.lsu_rsp_valid), 96'(e.lsu));
        check("rsp_data", 96'(e.lsu ? bus.lsu_rdata : bus.ifu_rdata), 96'(e.data));
      end
    end
    if (!bus.ifu_rsp_valid) check("ifu_rdata_zero", 96'(bus.ifu_rdata), 96'(0));
    if (!bus.lsu_rsp_valid) check("lsu_rdata_zero", 96'(bus.lsu_rdata), 96'(0));
  end

  task automatic wait_rsp(input string tag, input int target);
    int b = 3000;
    while (n_rsp < target && b > 0) begin
      @(negedge clk);
      b--;
    end
    check(tag, 96'(n_rsp >= target), 96'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         base;
    int         b;
    logic [9:0] got10;
    logic [4:0] got5;

    // reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_valid", 96'(bus.mem_req_valid), 96'(0));
    check("rst_rsp_valid", 96'({bus.ifu_rsp_valid, bus.lsu_rsp_valid}), 96'(0));
    check("rst_readys", 96'({bus.ifu_req_ready, bus.lsu_req_ready}), 96'(0));
    check("rst_mem_fields", 96'({bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask}), 96'(0));
    @(posedge clk);
    #1 rst = 1'b1;

    // single IFU fetch, back-to-back memory
    ifu_fix = 1'b1; ifu_fix_addr = 32'h8000_0000; ifu_left = 1;
    wait_rsp("t1_done", n_rsp + 1);
    check("t1_mem_lat", 96'(hs_cyc - g_cyc), 96'(1));
    check("t1_rsp_lat", 96'(rsp_cyc - g_cyc), 96'(2));
    ifu_fix = 1'b0;

    // both requesting continuously: four LSU grants then one IFU
    base = grants.size();
    ifu_left = 2; lsu_left = 8;
    wait_rsp("t2_done", n_rsp + 10);
    got10 = '0;
    if (grants.size() >= base + 10)
      for (int i = 0; i < 10; i++) got10[i] = grants[base + i];
    check("t2_order", 96'(got10), 96'(10'b01111_01111));

    // LSU store stalled by memory for 5 cycles
    lsu_fix = 1'b1;
    lsu_fix_req.addr = 32'h100; lsu_fix_req.wen = 1'b1;
    lsu_fix_req.wdata = 32'hDEAD_BEEF; lsu_fix_req.wmask = 4'hF;
    hold_cnt = 5; lsu_left = 1;
    wait_rsp("t3_done", n_rsp + 1);
    check("t3_accept_lat", 96'(hs_cyc - g_cyc), 96'(6));
    check("t3_rsp_lat", 96'(rsp_cyc - hs_cyc), 96'(1));
    lsu_fix = 1'b0;

    // spurious memory responses outside RESP
    spurious = 1'b1;
    base = n_rsp;
    repeat (4) @(posedge clk);
    #1 ifu_left = 3;
    wait_rsp("t4_done", n_rsp + 3);
    repeat (4) @(posedge clk);
    #1 spurious = 1'b0;
    check("t4_rsp_count", 96'(n_rsp), 96'(base + 3));

    // reset during RESP after the streak has been raised to 3
    base = n_hs;
    lsu_left = 3; ifu_left = 1;
    b = 2000;
    while (n_hs < base + 3 && b > 0) begin
      @(posedge clk);
      b--;
    end
    check("t5_reach_resp", 96'(n_hs), 96'(base + 3));
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_no_rsp", 96'({bus.ifu_rsp_valid, bus.lsu_rsp_valid}), 96'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    check("t5_flush", 96'(exp_rsp.size()), 96'(1));
    exp_rsp.delete();
    lsu_left = 4;
    base = grants.size();
    @(negedge clk);
    check("t5_idle", 96'(bus.mem_req_valid), 96'(0));
    check("t5_grant", 96'(bus.lsu_req_ready), 96'(1));
    wait_rsp("t5_done", n_rsp + 5);
    got5 = '0;
    if (grants.size() >= base + 5)
      for (int i = 0; i < 5; i++) got5[i] = grants[base + i];
    check("t5_order", 96'(got5), 96'(5'b01111));

    // mixed traffic with random memory stalls
    rand_ready = 1'b1;
    ifu_left = 6; lsu_left = 6;
    wait_rsp("t6_done", n_rsp + 12);
    rand_ready = 1'b0;

    repeat (3) @(posedge clk);
    check("sb_req_empty", 96'(exp_req.size()), 96'(0));
    check("sb_rsp_empty", 96'(exp_rsp.size()), 96'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/ifu_lsu_arb.md
IFU_LSU_ARB -- requirements
Module: ifu_lsu_arb

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all ports.
REQ-002 Parameter DATA_W, default 32, data width; mask width SHALL be DATA_W/8.
REQ-003 Parameter STREAK_MAX, default 4, max consecutive LSU grants while IFU waits.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 ifu_req_valid  in  1  IFU fetch request.
REQ-007 ifu_req_ready  out  1  IFU request accepted this cycle.
REQ-008 ifu_addr  in  ADDR_W  fetch address (PC).
REQ-009 ifu_rsp_valid  out  1  fetch data valid, one-cycle pulse.
REQ-010 ifu_rdata  out  DATA_W  fetched instruction.
REQ-011 lsu_req_valid  in  1  LSU load/store request.
REQ-012 lsu_req_ready  out  1  LSU request accepted this cycle.
REQ-013 lsu_addr  in  ADDR_W  load/store address.
REQ-014 lsu_wen  in  1  1 = store, 0 = load.
REQ-015 lsu_wdata  in  DATA_W  store data.
REQ-016 lsu_wmask  in  DATA_W/8  store byte mask.
REQ-017 lsu_rsp_valid  out  1  load data / store done, one-cycle pulse.
REQ-018 lsu_rdata  out  DATA_W  load data.
REQ-019 mem_req_valid  out  1  request to shared memory port.
REQ-020 mem_req_ready  in  1  memory accepts request.
REQ-021 mem_addr / mem_wen / mem_wdata / mem_wmask  out  ADDR_W / 1 / DATA_W / DATA_W/8  latched request fields.
REQ-022 mem_rsp_valid  in  1  memory response, one cycle.
REQ-023 mem_rdata  in  DATA_W  memory read data.

Function
REQ-024 FSM states IDLE, REQ, RESP; one transaction outstanding at a time.
REQ-025 IDLE: if any request valid, grant one, assert only the winner's *_req_ready combinationally that cycle, latch its fields and owner, go to REQ next cycle.
REQ-026 Arbitration: LSU wins ties unless streak == STREAK_MAX, then IFU wins; single requester always wins.
REQ-027 Streak counter: +1 on each LSU grant while ifu_req_valid=1, saturating at STREAK_MAX; cleared to 0 on any IFU grant; unchanged otherwise.
REQ-028 *_req_ready SHALL be 0 in REQ and RESP.
REQ-029 REQ: mem_req_valid=1, mem_* fields stable from latched values until mem_req_ready=1; then go to RESP next cycle.
REQ-030 IFU grants SHALL drive mem_wen=0, mem_wmask=0, mem_wdata=0.
REQ-031 RESP: on mem_rsp_valid=1, pulse owner's *_rsp_valid for that cycle with *_rdata=mem_rdata (combinational pass-through), go to IDLE next cycle.
REQ-032 Non-owner *_rsp_valid SHALL stay 0; *_rdata SHALL be 0 whenever its *_rsp_valid=0.
REQ-033 mem_rsp_valid SHALL be ignored in IDLE and REQ.
REQ-034 Minimum transaction: 3 cycles (grant, mem accept, response); next grant no earlier than the cycle after response.
REQ-035 Requesters' fields SHALL be sampled only at the handshake; later changes have no effect.

Reset
REQ-036 rst=0 at a rising edge: state IDLE, streak 0, latched fields 0, all valid/ready outputs 0 except IDLE-combinational readys.
REQ-037 Reset mid-transaction SHALL abandon it with no *_rsp_valid pulse; mem_req_valid drops the cycle after the reset edge.

Verification
REQ-038 IFU only, addr 0x80000000, mem ready + rsp immediate -> ifu_req_ready cycle 0, mem_req_valid cycle 1 with addr 0x80000000 wen 0, ifu_rsp_valid cycle 2 with rdata = mem_rdata.
REQ-039 Both valid continuously, STREAK_MAX=4 -> grant order LSU,LSU,LSU,LSU,IFU, repeating.
REQ-040 LSU store addr 0x100 wdata 0xDEADBEEF wmask 0xF, mem_req_ready held 0 for 5 cycles -> mem_* fields stable all 5 cycles, lsu_rsp_valid only after response.
REQ-041 Spurious mem_rsp_valid in IDLE and REQ -> no *_rsp_valid pulse, state unaffected.
REQ-042 rst=0 asserted in RESP -> no rsp pulse, IDLE next cycle, streak 0, next request granted normally.
